// File: rtl/smm_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic matrix-multiply array.
// It takes one A/B pair, clears the array, feeds skewed wavefronts and then hands the Y matrix downstream.
module smm_seq_ctrl #(
    parameter int N    = 3,
    parameter int BW   = 8,
    parameter int ACCW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*BW-1:0]     a_flat,
    input  logic [N*N*BW-1:0]     b_flat,
    output logic                  arr_clr,
    output logic                  arr_en,
    output logic [N*BW-1:0]       arr_a,
    output logic [N*BW-1:0]       arr_b,
    input  logic [N*N*ACCW-1:0]   arr_y,
    output logic [N*N*ACCW-1:0]   y_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | waiting for an operand pair (in_ready=1)
    // CLEAR   | one cycle of array accumulator clear
    // FEED    | 3N-2 cycles of skewed edge injection, t=0..3N-3
    // CAPTURE | array idle, arr_y registered into y_flat
    // DONE    | y_flat presented until out_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int FEED_LEN = 3 * N - 2;
    localparam int TW       = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(FEED_LEN - 1);

    state_t              state;
    state_t              next_state;
    logic [TW-1:0]       t;
    logic [N*N*BW-1:0]   a_reg;
    logic [N*N*BW-1:0]   b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (in_valid) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_FEED;
            S_FEED:    if (t == T_LAST) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_DONE;
            S_DONE:    if (out_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // The counter only ever moves inside FEED and is parked at zero otherwise,
    // so the first FEED cycle always starts at t=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            t      <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            y_flat <= '0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                a_reg <= a_flat;
                b_reg <= b_flat;
            end
            if (state == S_FEED && t != T_LAST) begin
                t <= t + 1'b1;
            end else begin
                t <= '0;
            end
            if (state == S_CAPTURE) begin
                y_flat <= arr_y;
            end
        end
    end

    // All handshake and array controls are forced low while rst is held.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        arr_clr   = 1'b0;
        arr_en    = 1'b0;
        arr_a     = '0;
        arr_b     = '0;
        out_valid = 1'b0;
        if (!rst) begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE:  in_ready = 1'b1;
                S_CLEAR: arr_clr  = 1'b1;
                S_FEED: begin
                    arr_en = 1'b1;
                    // West lane i carries A[i][t-i]; north lane j carries B[t-j][j].
                    for (int i = 0; i < N; i++) begin
                        if (int'(t) >= i && int'(t) < i + N) begin
                            arr_a[i*BW +: BW] = a_reg[(i*N + int'(t) - i)*BW +: BW];
                        end
                    end
                    for (int j = 0; j < N; j++) begin
                        if (int'(t) >= j && int'(t) < j + N) begin
                            arr_b[j*BW +: BW] = b_reg[((int'(t) - j)*N + j)*BW +: BW];
                        end
                    end
                end
                S_DONE:  out_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_smm_seq_ctrl.sv
// Bench for smm_seq_ctrl: a behavioural systolic array closes the loop,
// and a queue of expected Y matrices is checked by an independent output monitor.
module tb_smm_seq_ctrl;

    localparam int N    = 3;
    localparam int BW   = 8;
    localparam int ACCW = 16;

    typedef int mat_t [N][N];
    typedef logic [N*N*ACCW-1:0] yvec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [N*N*BW-1:0]   a_flat = '0;
    logic [N*N*BW-1:0]   b_flat = '0;
    logic                in_ready;
    logic                arr_clr;
    logic                arr_en;
    logic [N*BW-1:0]     arr_a;
    logic [N*BW-1:0]     arr_b;
    logic [N*N*ACCW-1:0] arr_y;
    logic [N*N*ACCW-1:0] y_flat;
    logic                out_valid;
    logic                busy;

    int    n_tests = 0;
    int    n_fail  = 0;
    yvec_t exp_q[$];
    bit    rand_ready = 1'b0;

    always #5 clk = ~clk;

    smm_seq_ctrl #(.N(N), .BW(BW), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .b_flat(b_flat), .arr_clr(arr_clr), .arr_en(arr_en),
        .arr_a(arr_a), .arr_b(arr_b), .arr_y(arr_y), .y_flat(y_flat),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Behavioural array: each PE multiplies, accumulates and forwards a east / b south.
    logic [ACCW-1:0] acc [N][N];
    logic [BW-1:0]   ap  [N][N];
    logic [BW-1:0]   bp  [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [BW-1:0] ain;
                logic [BW-1:0] bin;
                if (j == 0) ain = arr_a[i*BW +: BW];
                else        ain = ap[i][j-1];
                if (i == 0) bin = arr_b[j*BW +: BW];
                else        bin = bp[i-1][j];
                if (arr_clr) begin
                    acc[i][j] <= '0;
                    ap[i][j]  <= '0;
                    bp[i][j]  <= '0;
                end else if (arr_en) begin
                    acc[i][j] <= acc[i][j] + ACCW'(ain) * ACCW'(bin);
                    ap[i][j]  <= ain;
                    bp[i][j]  <= bin;
                end
            end
        end
    end

    always_comb begin
        arr_y = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_y[(i*N+j)*ACCW +: ACCW] = acc[i][j];
    end

    function automatic logic [N*N*BW-1:0] pack_m(input mat_t m);
        logic [N*N*BW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                p[(i*N+j)*BW +: BW] = BW'(m[i][j]);
        return p;
    endfunction

    function automatic yvec_t pack_y(input mat_t m);
        yvec_t p;
        p = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                p[(i*N+j)*ACCW +: ACCW] = ACCW'(m[i][j]);
        return p;
    endfunction

    // Plain matrix product, truncated to the accumulator width.
    function automatic yvec_t model_y(input mat_t a, input mat_t b);
        mat_t y;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                y[i][j] = 0;
                for (int k = 0; k < N; k++) y[i][j] += a[i][k] * b[k][j];
                y[i][j] = y[i][j] & ((1 << ACCW) - 1);
            end
        return pack_y(y);
    endfunction

    function automatic logic [N*BW-1:0] lane_a(input mat_t a, input int tt);
        logic [N*BW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (tt - i >= 0 && tt - i < N) v[i*BW +: BW] = BW'(a[i][tt-i]);
        return v;
    endfunction

    function automatic logic [N*BW-1:0] lane_b(input mat_t b, input int tt);
        logic [N*BW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (tt - j >= 0 && tt - j < N) v[j*BW +: BW] = BW'(b[tt-j][j]);
        return v;
    endfunction

    function automatic mat_t m_seq(input int start, input int step);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = start + step * (i*N + j);
        return m;
    endfunction

    function automatic mat_t m_ident();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = (i == j) ? 1 : 0;
        return m;
    endfunction

    function automatic mat_t m_rand();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic check(input string name, input yvec_t act, input yvec_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge, where all inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic send(input mat_t a, input mat_t b, input yvec_t expv, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        a_flat = pack_m(a);
        b_flat = pack_m(b);
        in_valid = 1'b1;
        while (!ok && waited < 60) begin
            @(negedge clk);
            ok = in_ready && in_valid;
            waited++;
            step();
        end
        in_valid = 1'b0;
        if (ok) exp_q.push_back(expv);
        check("accept", yvec_t'(ok), yvec_t'(1));
    endtask

    // One operation with out_ready held high, checking every cycle's controls.
    task automatic run_timed(input mat_t a, input mat_t b, input yvec_t expv, input bit skew);
        int w;
        out_ready = 1'b1;
        send(a, b, expv, w);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), yvec_t'(busy), yvec_t'(k <= 10));
            check($sformatf("out_valid_c%0d", k), yvec_t'(out_valid), yvec_t'(k == 10));
            check($sformatf("arr_clr_c%0d", k), yvec_t'(arr_clr), yvec_t'(k == 1));
            check($sformatf("arr_en_c%0d", k), yvec_t'(arr_en), yvec_t'(k >= 2 && k <= 8));
            check($sformatf("in_ready_c%0d", k), yvec_t'(in_ready), yvec_t'(k == 11));
            check($sformatf("arr_a_c%0d", k), yvec_t'(arr_a),
                  (k >= 2 && k <= 8) ? yvec_t'(lane_a(a, k - 2)) : yvec_t'(0));
            check($sformatf("arr_b_c%0d", k), yvec_t'(arr_b),
                  (k >= 2 && k <= 8) ? yvec_t'(lane_b(b, k - 2)) : yvec_t'(0));
            if (skew && k == 4) begin
                check("skew_arr_a_t2", yvec_t'(arr_a), yvec_t'(24'h070503));
                check("skew_arr_b_t2", yvec_t'(arr_b), yvec_t'(24'h070503));
            end
        end
        step();
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            step();
            c++;
        end
        check("drain", yvec_t'(exp_q.size()), yvec_t'(0));
    endtask

    // Output monitor: every handshake on the output side consumes one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected nothing", y_flat);
                end else begin
                    check("y_flat", y_flat, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t  ai, b19, a19, b91, a255, ra, rb, p1a, p1b;
        yvec_t saved;
        bit    got;
        int    w;

        ai   = m_ident();
        b19  = m_seq(1, 1);
        a19  = m_seq(1, 1);
        b91  = m_seq(9, -1);
        a255 = m_seq(255, 0);

        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("rst_in_ready", yvec_t'(in_ready), yvec_t'(0));
        check("rst_busy", yvec_t'(busy), yvec_t'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", yvec_t'(in_ready), yvec_t'(1));
        check("post_rst_outs", yvec_t'({arr_clr, arr_en, arr_a, arr_b, out_valid, busy}), yvec_t'(0));
        check("post_rst_y", y_flat, yvec_t'(0));
        step();

        run_timed(ai, b19, pack_y(m_seq(1, 1)), 1'b0);
        run_timed(a19, b91, pack_y('{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}}), 1'b1);
        run_timed(a255, a255, pack_y(m_seq(64003, 0)), 1'b0);
        drain();

        // Backpressure: new operands are offered throughout the first operation.
        p1a = m_rand();
        p1b = m_rand();
        out_ready = 1'b0;
        send(p1a, p1b, model_y(p1a, p1b), w);
        a_flat = pack_m(a19);
        b_flat = pack_m(b91);
        in_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = out_valid;
        end
        check("bp_out_valid", yvec_t'(got), yvec_t'(1));
        saved = y_flat;
        check("bp_y_value", y_flat, model_y(p1a, p1b));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", yvec_t'(out_valid), yvec_t'(1));
            check("bp_hold_in_ready", yvec_t'(in_ready), yvec_t'(0));
            check("bp_hold_y", y_flat, saved);
        end
        step();
        out_ready = 1'b1;
        step();
        send(a19, b91, model_y(a19, b91), w);
        check("bp_next_accept_cycles", yvec_t'(w), yvec_t'(1));
        drain();

        // Reset in the middle of FEED, at t=3.
        out_ready = 1'b1;
        send(a255, b91, model_y(a255, b91), w);
        repeat (3) step();
        @(negedge clk);
        check("mid_feed_arr_en", yvec_t'(arr_en), yvec_t'(1));
        step();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_in_ready", yvec_t'(in_ready), yvec_t'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("after_abort_outs", yvec_t'({arr_clr, arr_en, arr_a, arr_b, out_valid, busy}), yvec_t'(0));
        check("after_abort_y", y_flat, yvec_t'(0));
        check("after_abort_in_ready", yvec_t'(in_ready), yvec_t'(1));
        step();
        run_timed(ai, b19, pack_y(m_seq(1, 1)), 1'b0);
        drain();

        // Random operands with random downstream readiness.
        rand_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            ra = m_rand();
            rb = m_rand();
            send(ra, rb, model_y(ra, rb), w);
            repeat ($urandom_range(0, 3)) step();
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/smm_seq_ctrl.md
Name: smm_seq_ctrl

Overview:
- Sequencer for the NxN output-stationary systolic matrix-multiply array (SMM datapath).
- Accepts one A/B operand pair through a valid/ready handshake and clears the array accumulators.
- Streams skewed row/column wavefronts into the array edges, then captures the finished Y matrix.
- Presents Y downstream with a valid/ready handshake; sits between the operand source and the SMM array.

Parameters:
- N, 3, matrix dimension (array is NxN).
- BW, 8, operand width (unsigned).
- ACCW, 16, accumulator/result width (2*BW); results wrap mod 2^ACCW.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- a_flat  in  N*N*BW  A[i][j] at bits [(i*N+j)*BW +: BW].
- b_flat  in  N*N*BW  B[i][j], same packing.
- arr_clr  out  1  array accumulator clear (all PEs acc<=0, pipeline regs<=0).
- arr_en  out  1  array MAC/shift enable.
- arr_a  out  N*BW  west-edge lane i at [i*BW +: BW].
- arr_b  out  N*BW  north-edge lane j at [j*BW +: BW].
- arr_y  in  N*N*ACCW  array accumulators, (i*N+j) packing.
- y_flat  out  N*N*ACCW  captured result, same packing.
- out_valid  out  1  y_flat valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Array contract: with arr_en=1, PE(i,j) does acc+=a_in*b_in and forwards a east and b south through one register each. Edge data injected at cycle t reaches PE(i,j) at cycle t+j (a) or t+i (b).
- States: IDLE, CLEAR, FEED, CAPTURE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_flat/b_flat into internal regs, go to CLEAR.
- CLEAR (1 cycle):
  - arr_clr=1, arr_en=0, arr_a/arr_b=0.
  - Go to FEED with t=0.
- FEED (3N-2 cycles, t=0..3N-3):
  - arr_en=1.
  - Lane i: arr_a = A[i][t-i] if 0<=t-i<N, else 0.
  - Lane j: arr_b = B[t-j][j] if 0<=t-j<N, else 0.
  - t increments each cycle. After t=3N-3, go to CAPTURE.
  - Counter width is clog2(3N-2); no wrap occurs within FEED.
- CAPTURE (1 cycle):
  - arr_en=0, edges 0.
  - y_flat<=arr_y, registered at the end of this cycle.
  - Go to DONE.
- DONE:
  - out_valid=1, y_flat held stable.
  - On out_valid&out_ready: go to IDLE.
  - out_valid must not drop without a handshake.
- Timing for N=3: accept at edge 0; CLEAR cycle 1; FEED cycles 2..8; CAPTURE cycle 9; out_valid high from cycle 10. Accept-to-out_valid latency is 3N+1 = 10 cycles.
- in_ready=0 outside IDLE. in_valid is ignored in those states, and the operand regs are not overwritten.
- Back-to-back: the handshake cycle returns to IDLE. The next accept is in the following cycle, so there is a 1-cycle minimum gap.
- Arithmetic: unsigned. Overflow wraps mod 2^ACCW inside the array; the controller does no saturation.
- Outputs low/zero in every state not listed above: arr_clr, arr_en, arr_a, arr_b, out_valid.
- Reset values (rst=1 at a clock edge, from any state, including mid-FEED or DONE):
  - state=IDLE, t=0.
  - in_ready=0 during the reset cycle, 1 from the first cycle after rst deasserts.
  - arr_clr=0, arr_en=0, arr_a=0, arr_b=0, y_flat=0, out_valid=0, busy=0.
  - Operand regs are cleared to 0.
  - The array is not cleared by reset. The next operation's CLEAR guarantees a clean start.
- rst has priority over every handshake in the same cycle.

Test Plan:
- Identity: A=I, B={1..9} row-major, out_ready=1 → out_valid exactly 10 cycles after accept; y_flat={1,2,3,4,5,6,7,8,9}; busy high for cycles 1..10.
- General: A={1..9}, B={9..1} → Y={30,24,18,84,69,54,138,114,90}.
- Skew check on the same stimulus at FEED t=2 → arr_a lanes = {A[0][2], A[1][1], A[2][0]} = {3,5,7}; arr_b lanes = {B[2][0], B[1][1], B[0][2]} = {3,5,7}.
- Overflow: all A, B = 255 → every Y entry = 195075 mod 65536 = 64003.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands → y_flat stable, in_ready=0, new operands not latched; on out_ready=1, handshake, IDLE, the new pair is accepted the next cycle and its result is correct.
- Reset mid-FEED: assert rst at t=3 for 1 cycle → all outputs zero; next operation (identity × {1..9}) gives correct Y with no residue from the aborted run.
